// File: rtl/clint_timer.sv
// ----------------------------------------------------------------------------
// clint_timer
//   Memory-mapped machine timer. It holds a 64-bit mtime counter and a 64-bit
//   mtimecmp register, and raises o_tip while mtime >= mtimecmp. It is a
//   word-addressed slave on the data-memory bus and acks every access one
//   cycle after the request.
//
//   Register map (byte offsets, bits [1:0] of the address are ignored):
//     0x00 mtime[31:0]    (a read also snapshots mtime[63:32] into hi-shadow)
//     0x04 mtime[63:32]   (reads return hi-shadow, writes go to live mtime)
//     0x08 mtimecmp[31:0]
//     0x0C mtimecmp[63:32]
//     0x10 ctrl           (bit0 = count enable, other bits read 0)
//     0x14 msip           (bit0, only when CLINT_MSIP_EN is defined)
//     others              read 0, writes ignored
//
//   Bus handshake: i_bus_en is a one-cycle request strobe sampled at a rising
//   edge N. A write updates the register at edge N. o_bus_ack is high for
//   exactly the cycle after N; back-to-back requests give back-to-back acks.
//   o_bus_rdata carries the addressed register value as it was just before
//   edge N (write acks return the pre-write value), and is 0 when no ack.
//
//   Build option: define CLINT_MSIP_EN to add the software-interrupt register
//   at 0x14 and drive o_sip from it; otherwise 0x14 reads 0 and o_sip is 0.
// ----------------------------------------------------------------------------
module clint_timer #(
    parameter int unsigned PRESCALE = 1,
    parameter logic [63:0] CMP_RST  = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_bus_en,
    input  logic        i_bus_we,
    input  logic [4:0]  i_bus_addr,
    input  logic [31:0] i_bus_wdata,
    output logic [31:0] o_bus_rdata,
    output logic        o_bus_ack,
    output logic        o_tip,
    output logic        o_sip
);

    // Prescaler counter width; at least one bit so PRESCALE=1 still builds.
    localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    // Word indices of the register map.
    localparam logic [2:0] IDX_MTIME_LO = 3'd0;
    localparam logic [2:0] IDX_MTIME_HI = 3'd1;
    localparam logic [2:0] IDX_CMP_LO   = 3'd2;
    localparam logic [2:0] IDX_CMP_HI   = 3'd3;
    localparam logic [2:0] IDX_CTRL     = 3'd4;
    localparam logic [2:0] IDX_MSIP     = 3'd5;

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    logic [63:0]     mtime_q;
    logic [63:0]     mtimecmp_q;
    logic            ctrl_en_q;
    logic [PS_W-1:0] ps_cnt_q;
    logic [31:0]     hi_shadow_q;

    // Next-state values
    logic [63:0]     mtime_d;
    logic [63:0]     mtimecmp_d;
    logic            ctrl_en_d;
    logic [PS_W-1:0] ps_cnt_d;
    logic [31:0]     hi_shadow_d;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [2:0] word_idx;
    logic       rd_req;
    logic       wr_req;
    logic       wr_mtime_lo;
    logic       wr_mtime_hi;
    logic       wr_cmp_lo;
    logic       wr_cmp_hi;
    logic       wr_ctrl;
    logic       rd_mtime_lo;
    logic       tick;
    logic [31:0] rd_mux;

    // Byte-lane bits carry no meaning for word-only accesses.
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_bus_addr[1:0];

    assign word_idx    = i_bus_addr[4:2];
    assign rd_req      = i_bus_en & ~i_bus_we;
    assign wr_req      = i_bus_en &  i_bus_we;
    assign wr_mtime_lo = wr_req && (word_idx == IDX_MTIME_LO);
    assign wr_mtime_hi = wr_req && (word_idx == IDX_MTIME_HI);
    assign wr_cmp_lo   = wr_req && (word_idx == IDX_CMP_LO);
    assign wr_cmp_hi   = wr_req && (word_idx == IDX_CMP_HI);
    assign wr_ctrl     = wr_req && (word_idx == IDX_CTRL);
    assign rd_mtime_lo = rd_req && (word_idx == IDX_MTIME_LO);

    // A tick is the last prescaler count of an enabled cycle.
    assign tick = ctrl_en_q && (ps_cnt_q == PS_LAST);

    // ------------------------------------------------------------------
    // Optional software interrupt register
    // ------------------------------------------------------------------
`ifdef CLINT_MSIP_EN
    logic msip_q;
    logic wr_msip;

    assign wr_msip = wr_req && (word_idx == IDX_MSIP);

    // msip register: bit0 of a write to 0x14, visible on o_sip from the next cycle.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            msip_q <= 1'b0;
        end else if (wr_msip) begin
            msip_q <= i_bus_wdata[0];
        end
    end

    assign o_sip = msip_q;
`else
    assign o_sip = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------

    // Prescaler: a write to either mtime half restarts it; ctrl.en=0 freezes it.
    always_comb begin
        ps_cnt_d = ps_cnt_q;
        if (wr_mtime_lo || wr_mtime_hi) begin
            ps_cnt_d = '0;
        end else if (ctrl_en_q) begin
            if (ps_cnt_q == PS_LAST) begin
                ps_cnt_d = '0;
            end else begin
                ps_cnt_d = ps_cnt_q + 1'b1;
            end
        end
    end

    // mtime: a bus write to either half wins over the tick and suppresses it.
    always_comb begin
        mtime_d = mtime_q;
        if (wr_mtime_lo) begin
            mtime_d = {mtime_q[63:32], i_bus_wdata};
        end else if (wr_mtime_hi) begin
            mtime_d = {i_bus_wdata, mtime_q[31:0]};
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    // mtimecmp halves and the ctrl enable bit are plain write-through registers.
    always_comb begin
        mtimecmp_d = mtimecmp_q;
        ctrl_en_d  = ctrl_en_q;
        if (wr_cmp_lo) begin
            mtimecmp_d[31:0] = i_bus_wdata;
        end
        if (wr_cmp_hi) begin
            mtimecmp_d[63:32] = i_bus_wdata;
        end
        if (wr_ctrl) begin
            ctrl_en_d = i_bus_wdata[0];
        end
    end

    // Hi-shadow: a read of mtime_lo snapshots the upper half for a tear-free 64-bit read.
    always_comb begin
        hi_shadow_d = hi_shadow_q;
        if (rd_mtime_lo) begin
            hi_shadow_d = mtime_q[63:32];
        end
    end

    // Read mux: register values as they stand before the sampling edge.
    always_comb begin
        rd_mux = 32'd0;
        case (word_idx)
            IDX_MTIME_LO: rd_mux = mtime_q[31:0];
            IDX_MTIME_HI: rd_mux = hi_shadow_q;
            IDX_CMP_LO:   rd_mux = mtimecmp_q[31:0];
            IDX_CMP_HI:   rd_mux = mtimecmp_q[63:32];
            IDX_CTRL:     rd_mux = {31'd0, ctrl_en_q};
`ifdef CLINT_MSIP_EN
            IDX_MSIP:     rd_mux = {31'd0, msip_q};
`else
            IDX_MSIP:     rd_mux = 32'd0;
`endif
            default:      rd_mux = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------

    // Timer state: counter, compare, enable, prescaler and hi-shadow.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            mtime_q     <= 64'd0;
            mtimecmp_q  <= CMP_RST;
            ctrl_en_q   <= 1'b1;
            ps_cnt_q    <= '0;
            hi_shadow_q <= 32'd0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            ctrl_en_q   <= ctrl_en_d;
            ps_cnt_q    <= ps_cnt_d;
            hi_shadow_q <= hi_shadow_d;
        end
    end

    // Bus response: one ack per request, read data only alongside the ack.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_bus_ack   <= 1'b0;
            o_bus_rdata <= 32'd0;
        end else begin
            o_bus_ack   <= i_bus_en;
            o_bus_rdata <= i_bus_en ? rd_mux : 32'd0;
        end
    end

    // Timer interrupt: registered compare of the current register contents,
    // so o_tip follows a change of mtime/mtimecmp by exactly one cycle.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_tip <= 1'b0;
        end else begin
            o_tip <= (mtime_q >= mtimecmp_q);
        end
    end

endmodule

// File: tb/tb_clint_timer.sv
// ----------------------------------------------------------------------------
// tb_clint_timer
//   Directed plus randomized bench for clint_timer with PRESCALE=4.
//   The reference model tracks mtime as "anchor value + enabled edges since
//   the anchor / PRESCALE", where the anchor is reset or the last mtime write.
// ----------------------------------------------------------------------------
module tb_clint_timer;

    localparam int unsigned P = 4;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_bus_en = 1'b0;
    logic        i_bus_we = 1'b0;
    logic [4:0]  i_bus_addr = 5'd0;
    logic [31:0] i_bus_wdata = 32'd0;
    logic [31:0] o_bus_rdata;
    logic        o_bus_ack;
    logic        o_tip;
    logic        o_sip;

    int checks = 0;
    int failures = 0;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    always #5 i_clk = ~i_clk;

    clint_timer #(
        .PRESCALE(P)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_bus_en    (i_bus_en),
        .i_bus_we    (i_bus_we),
        .i_bus_addr  (i_bus_addr),
        .i_bus_wdata (i_bus_wdata),
        .o_bus_rdata (o_bus_rdata),
        .o_bus_ack   (o_bus_ack),
        .o_tip       (o_tip),
        .o_sip       (o_sip)
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [63:0] m_base;
    logic [63:0] m_cnt;
    logic [63:0] m_cmp;
    logic        m_en;
    logic [31:0] m_shadow;
    logic        m_msip;
    logic        m_tip;

    task automatic m_reset();
        m_base   = 64'd0;
        m_cnt    = 64'd0;
        m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
        m_en     = 1'b1;
        m_shadow = 32'd0;
        m_msip   = 1'b0;
        m_tip    = 1'b0;
    endtask

    function automatic logic [63:0] m_mtime();
        return m_base + (m_cnt / 64'(P));
    endfunction

    function automatic logic m_tick_next();
        return m_en && ((m_cnt % 64'(P)) == 64'(P - 1));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        logic [63:0] mt;
        mt = m_mtime();
        case (a[4:2])
            3'd0:    return mt[31:0];
            3'd1:    return m_shadow;
            3'd2:    return m_cmp[31:0];
            3'd3:    return m_cmp[63:32];
            3'd4:    return {31'd0, m_en};
            3'd5:    return {31'd0, m_msip};
            default: return 32'd0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard check
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver: one bus cycle (or idle cycle), model update, output checks
    // ------------------------------------------------------------------
    task automatic cycle(input logic en, input logic we, input logic [4:0] addr,
                         input logic [31:0] wd, input string tag,
                         output logic [31:0] rd);
        logic [63:0] mt_pre;
        logic [31:0] exp_rd;
        i_bus_en    = en;
        i_bus_we    = we;
        i_bus_addr  = addr;
        i_bus_wdata = wd;
        mt_pre = m_mtime();
        exp_rd = en ? m_read(addr) : 32'd0;
        @(posedge i_clk);
        // o_tip registers the compare of the values held before this edge.
        m_tip = (mt_pre >= m_cmp);
        if (en && !we && addr[4:2] == 3'd0) m_shadow = mt_pre[63:32];
        if (m_en) m_cnt = m_cnt + 64'd1;
        if (en && we) begin
            case (addr[4:2])
                3'd0: begin m_base = {mt_pre[63:32], wd}; m_cnt = 64'd0; end
                3'd1: begin m_base = {wd, mt_pre[31:0]};  m_cnt = 64'd0; end
                3'd2: m_cmp[31:0]  = wd;
                3'd3: m_cmp[63:32] = wd;
                3'd4: m_en = wd[0];
`ifdef CLINT_MSIP_EN
                3'd5: m_msip = wd[0];
`endif
                default: ;
            endcase
        end
        #1;
        check({tag, ".ack"},   64'(o_bus_ack),   64'(en));
        check({tag, ".rdata"}, 64'(o_bus_rdata), 64'(exp_rd));
        check({tag, ".tip"},   64'(o_tip),       64'(m_tip));
        check({tag, ".sip"},   64'(o_sip),       64'(m_msip));
        rd = o_bus_rdata;
        i_bus_en = 1'b0;
        i_bus_we = 1'b0;
    endtask

    task automatic rd_reg(input logic [4:0] addr, input string tag, output logic [31:0] rd);
        cycle(1'b1, 1'b0, addr, 32'd0, tag, rd);
    endtask

    task automatic wr_reg(input logic [4:0] addr, input logic [31:0] wd, input string tag);
        logic [31:0] unused_rd;
        cycle(1'b1, 1'b1, addr, wd, tag, unused_rd);
    endtask

    task automatic idle(input int n, input string tag);
        logic [31:0] unused_rd;
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 5'd0, 32'd0, tag, unused_rd);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stim
        logic [31:0] rd;
        logic [4:0]  ra;
        logic [31:0] wd;
        int          r;

        // Reset held with a request pending: no ack, all outputs quiet.
        i_bus_en = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst.ack",   64'(o_bus_ack),   64'd0);
        check("rst.rdata", 64'(o_bus_rdata), 64'd0);
        check("rst.tip",   64'(o_tip),       64'd0);
        check("rst.sip",   64'(o_sip),       64'd0);
        i_bus_en = 1'b0;
        i_rst = 1'b1;
        m_reset();

        // Read every offset straight out of reset.
        rd_reg(5'h08, "rst_cmp_lo", rd);
        check("rst_cmp_lo.const", 64'(rd), 64'hFFFF_FFFF);
        rd_reg(5'h0C, "rst_cmp_hi", rd);
        check("rst_cmp_hi.const", 64'(rd), 64'hFFFF_FFFF);
        rd_reg(5'h10, "rst_ctrl", rd);
        check("rst_ctrl.const", 64'(rd), 64'd1);
        rd_reg(5'h04, "rst_mtime_hi", rd);
        check("rst_mtime_hi.const", 64'(rd), 64'd0);
        rd_reg(5'h18, "rst_unmapped", rd);
        check("rst_unmapped.const", 64'(rd), 64'd0);
        rd_reg(5'h1C, "rst_unmapped2", rd);
        rd_reg(5'h14, "rst_msip", rd);
        rd_reg(5'h00, "rst_mtime_lo", rd);

        // 40 enabled cycles after reset with PRESCALE=4: about 10 ticks.
        m_reset();
        i_rst = 1'b0;
        #2;
        i_rst = 1'b1;
        idle(40, "count40");
        rd_reg(5'h00, "count40_rd", rd);
        check("count40.range", 64'(rd >= 32'd9 && rd <= 32'd11), 64'd1);

        // Disable counting: mtime freezes for 40 cycles.
        wr_reg(5'h10, 32'd0, "ctrl_off");
        idle(40, "frozen");
        rd_reg(5'h00, "frozen_rd", rd);
        check("frozen.value", 64'(rd), 64'(m_base[31:0] + 32'(m_cnt / 64'(P))));
        wr_reg(5'h13, 32'hFFFF_FFFF, "ctrl_on");

        // Atomic 64-bit read: shadow holds the hi half from the lo read.
        wr_reg(5'h04, 32'hFFFF_FFF0, "carry_hi");
        wr_reg(5'h00, 32'hFFFF_FFFE, "carry_lo");
        rd_reg(5'h00, "carry_rd_lo", rd);
        check("carry_rd_lo.const", 64'(rd), 64'hFFFF_FFFE);
        idle(10, "carry_wait");
        rd_reg(5'h04, "carry_rd_hi", rd);
        check("carry_rd_hi.shadow", 64'(rd), 64'hFFFF_FFF0);
        rd_reg(5'h00, "carry_rd_lo2", rd);
        rd_reg(5'h04, "carry_rd_hi2", rd);
        check("carry_rd_hi2.live", 64'(rd), 64'hFFFF_FFF1);

        // 64-bit wrap 2^64-1 -> 0.
        wr_reg(5'h04, 32'hFFFF_FFFF, "wrap_hi");
        wr_reg(5'h00, 32'hFFFF_FFFF, "wrap_lo");
        idle(5, "wrap_wait");
        rd_reg(5'h00, "wrap_rd_lo", rd);
        check("wrap_rd_lo.const", 64'(rd), 64'd0);
        rd_reg(5'h04, "wrap_rd_hi", rd);
        check("wrap_rd_hi.const", 64'(rd), 64'd0);

        // Timer interrupt around the equality boundary, then cleared by mtimecmp.
        wr_reg(5'h08, 32'd100, "tip_cmp_lo");
        wr_reg(5'h04, 32'd0,   "tip_mt_hi");
        wr_reg(5'h00, 32'd95,  "tip_mt_lo");
        wr_reg(5'h0C, 32'd0,   "tip_cmp_hi");
        idle(30, "tip_run");
        check("tip_run.level", 64'(o_tip), 64'd1);
        wr_reg(5'h08, 32'd500, "tip_raise_cmp");
        idle(2, "tip_fall");
        check("tip_fall.level", 64'(o_tip), 64'd0);
        // Lowering mtime below mtimecmp also clears it.
        wr_reg(5'h00, 32'd600, "tip_mt_high");
        idle(2, "tip_set_again");
        check("tip_set_again.level", 64'(o_tip), 64'd1);
        wr_reg(5'h00, 32'd3, "tip_mt_low");
        idle(2, "tip_clear_again");
        check("tip_clear_again.level", 64'(o_tip), 64'd0);

        // mtime_lo write on a tick cycle: no increment, prescaler restarts.
        for (int k = 0; k < int'(P) && !m_tick_next(); k++) idle(1, "find_tick");
        check("find_tick.aligned", 64'(m_tick_next()), 64'd1);
        wr_reg(5'h00, 32'd7, "tick_wr");
        rd_reg(5'h00, "tick_rd0", rd);
        check("tick_rd0.const", 64'(rd), 64'd7);
        idle(2, "tick_gap");
        rd_reg(5'h00, "tick_rd1", rd);
        check("tick_rd1.const", 64'(rd), 64'd7);
        rd_reg(5'h00, "tick_rd2", rd);
        check("tick_rd2.const", 64'(rd), 64'd8);

        // Software interrupt register (present only with CLINT_MSIP_EN).
        wr_reg(5'h14, 32'd1, "msip_wr");
`ifdef CLINT_MSIP_EN
        check("msip_wr.sip", 64'(o_sip), 64'd1);
`else
        check("msip_wr.sip", 64'(o_sip), 64'd0);
`endif
        rd_reg(5'h14, "msip_rd", rd);
`ifdef CLINT_MSIP_EN
        check("msip_rd.const", 64'(rd), 64'd1);
`else
        check("msip_rd.const", 64'(rd), 64'd0);
`endif
        wr_reg(5'h14, 32'd0, "msip_clr");

        // Randomized traffic, back-to-back requests included.
        for (int n = 0; n < 600; n++) begin
            r  = $urandom_range(0, 9);
            ra = {3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 3) == 0) wd = $urandom;
            else wd = 32'($urandom_range(0, 64));
            if (ra[4:2] == 3'd1 || ra[4:2] == 3'd3) wd = 32'($urandom_range(0, 1));
            if (ra[4:2] == 3'd4) wd = 32'($urandom_range(0, 3) != 0);
            if (r < 3) idle(1, "rnd_idle");
            else if (r < 7) rd_reg(ra, "rnd_rd", rd);
            else wr_reg(ra, wd, "rnd_wr");
        end

        // Reset asserted mid-access drops the access.
        i_bus_en   = 1'b1;
        i_bus_we   = 1'b0;
        i_bus_addr = 5'h08;
        #2;
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        check("midrst.ack",   64'(o_bus_ack),   64'd0);
        check("midrst.rdata", 64'(o_bus_rdata), 64'd0);
        check("midrst.tip",   64'(o_tip),       64'd0);
        i_bus_en = 1'b0;
        i_rst = 1'b1;
        m_reset();
        rd_reg(5'h08, "post_rst_cmp", rd);
        check("post_rst_cmp.const", 64'(rd), 64'hFFFF_FFFF);
        rd_reg(5'h10, "post_rst_ctrl", rd);
        check("post_rst_ctrl.const", 64'(rd), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
